umem_arbiter: RTL and testbench
===============================

# umem_arbiter

Two-requester arbiter for the single-ported unified memory (umem). It shares one memory port between the instruction-fetch requester (read-only) and the load/store data requester (read/write). Per-requester request/grant handshakes, fixed data priority with a fetch starvation guard, and a lock that holds the port for atomic read-modify-write. Sits between the core's fetch/LSU stages and the umem instance.

## Interface

Parameters:
- MAX_DATA_BURST, default 4: consecutive data grants allowed while fetch waits before fetch is forced through (legal range 1..15).

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- if_req  in  1  fetch requests a read this cycle
- if_addr  in  32  fetch byte address
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  fetch read data valid on if_rdata
- if_rdata  out  32  fetch read data
- d_req  in  1  data requester requests an access this cycle
- d_rw  in  1  1 = write, 0 = read
- d_lock  in  1  hold the port for data after this grant (atomic RMW)
- d_addr  in  32  data byte address
- d_wdata  in  32  write data
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  data read data valid on d_rdata
- d_rdata  out  32  data read data
- mem_addr  out  32  umem address
- mem_wdata  out  32  umem write data
- mem_rw  out  1  umem write enable (1 = write)
- mem_rdata  in  32  umem read data, valid one cycle after the read is presented

## Operation

- Transfer occurs in a cycle where req && gnt. At most one grant per cycle. Grants are combinational from current requests and registered state.
- umem port driven combinationally from the granted requester: mem_addr/mem_wdata/mem_rw = winner's addr/wdata/rw (fetch: mem_rw=0, mem_wdata=0). No grant: mem_rw=0, mem_addr and mem_wdata = 0.
- Arbitration (state OPEN):
  - only one requester: it wins.
  - both: data wins unless burst_cnt == MAX_DATA_BURST, then fetch wins.
- burst_cnt (width 4): increments on a data grant while if_req=1, saturating at MAX_DATA_BURST; clears on a fetch grant or any cycle with if_req=0.
- Lock FSM, states OPEN and LOCKED:
  - OPEN -> LOCKED: data granted with d_lock=1.
  - LOCKED: fetch never granted regardless of burst_cnt; data granted whenever d_req=1; burst_cnt keeps counting (saturates).
  - LOCKED -> OPEN: any cycle with d_lock=0 (evaluated at clock edge; the same cycle's arbitration still treats the port as LOCKED).
- Read response: a granted read sets rsp_owner (NONE/IF/D) at the edge; next cycle the owner's rvalid=1 and its rdata = mem_rdata; non-owner rdata = 0. One read may be in flight while the next request is granted (full throughput, one access per cycle).
- Writes produce no response; committed by umem on the grant edge.

## Timing

- Reset (sync, sampled on edge): state=OPEN, burst_cnt=0, rsp_owner=NONE. While reset=1: if_gnt=d_gnt=0, if_rvalid=d_rvalid=0, if_rdata=d_rdata=0, mem_rw=0, mem_addr=mem_wdata=0.
- Reset during an outstanding read: the response is dropped; no rvalid in the cycle after reset deasserts.
- Grant latency 0 cycles; read data latency exactly 1 cycle after grant.
- Requesters hold req/addr/wdata stable until granted; the arbiter keeps no request buffers.
- Simultaneous d_req with d_lock=0 while LOCKED: granted, state returns to OPEN next edge.
- MAX_DATA_BURST saturation: fetch wins on the cycle after the Nth consecutive data grant with if_req high.

## Test plan

- Fetch only: if_req=1, if_addr=0x10 with mem holding 0xDEADBEEF -> if_gnt=1 same cycle, mem_addr=0x10, mem_rw=0; next cycle if_rvalid=1, if_rdata=0xDEADBEEF, d_rvalid=0.
- Contention: if_req and d_req (read 0x40) both held 6 cycles, MAX_DATA_BURST=4 -> grants D,D,D,D,IF,D; rvalids follow one cycle later on matching owner.
- Write: d_req=1, d_rw=1, d_addr=0x80, d_wdata=0x12345678 -> d_gnt=1, mem_rw=1, mem_wdata=0x12345678; no d_rvalid next cycle; later read of 0x80 returns 0x12345678.
- Lock: d_req+d_lock read 0x20 then write 0x20 with if_req held, d_lock held 6 cycles -> if_gnt=0 throughout lock despite burst_cnt saturating; fetch granted first cycle after d_lock drops and data idle.
- Reset mid-read: grant fetch read, assert reset next cycle -> if_rvalid=0, all outputs 0 during reset; after release first fetch proceeds normally, state OPEN.
- Back-to-back: fetch reads 0x0,0x4,0x8 on consecutive cycles -> if_gnt=1 each cycle, if_rvalid=1 for three cycles with data in order.

Source files
------------

// File: rtl/umem_arbiter.sv
// -----------------------------------------------------------------------------
// umem_arbiter
//
// Shares the single port of the unified memory between the instruction-fetch
// requester (read-only) and the load/store data requester (read/write).
// Data has fixed priority. A starvation guard forces fetch through after
// MAX_DATA_BURST consecutive data grants while fetch waits. A lock lets the
// data side hold the port for an atomic read-modify-write.
//
// Parameters:
//   MAX_DATA_BURST  consecutive data grants tolerated while fetch waits (1..15)
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   if_req/if_addr              fetch read request
//   if_gnt                      fetch request accepted this cycle
//   if_rvalid/if_rdata          fetch read response, one cycle after grant
//   d_req/d_rw/d_lock           data request, 1 = write, hold port after grant
//   d_addr/d_wdata              data address and write data
//   d_gnt                       data request accepted this cycle
//   d_rvalid/d_rdata            data read response, one cycle after grant
//   mem_addr/mem_wdata/mem_rw   umem port, driven from the granted requester
//   mem_rdata                   umem read data, valid one cycle after the read
// -----------------------------------------------------------------------------
module umem_arbiter #(
  parameter int unsigned MAX_DATA_BURST = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_rw,
  input  logic        d_lock,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_rw,
  input  logic [31:0] mem_rdata
);

  typedef enum logic {
    S_OPEN,
    S_LOCKED
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IF,
    OWN_D
  } owner_t;

  localparam logic [3:0] BURST_MAX = 4'(MAX_DATA_BURST);

  state_t     state;
  state_t     state_next;
  logic [3:0] burst_cnt;
  logic [3:0] burst_next;
  owner_t     rsp_owner;
  owner_t     owner_next;

  // ---------------------------------------------------------------------------
  // State register: lock FSM, starvation counter and read-response owner.
  // ---------------------------------------------------------------------------
  // NOTE: registers use non-blocking assignments so every flop samples the
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_OPEN;
      burst_cnt <= '0;
      rsp_owner <= OWN_NONE;
    end else begin
      state     <= state_next;
      burst_cnt <= burst_next;
      rsp_owner <= owner_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic.
  // ---------------------------------------------------------------------------
  // NOTE: every signal gets a default at the top of a combinational block, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      S_OPEN:   if (d_gnt && d_lock) state_next = S_LOCKED;
      // d_lock is sampled at the edge; this cycle still arbitrates as LOCKED.
      S_LOCKED: if (!d_lock)         state_next = S_OPEN;
      default:  state_next = S_OPEN;
    endcase
  end

  // Starvation counter: counts data grants that made a waiting fetch lose.
  // Any fetch grant or a cycle without a fetch request restarts the count.
  always_comb begin
    burst_next = burst_cnt;
    if (!if_req || if_gnt) begin
      burst_next = '0;
    end else if (d_gnt && (burst_cnt != BURST_MAX)) begin
      burst_next = burst_cnt + 4'd1;
    end
  end

  // Only reads produce a response; the owner selects who sees mem_rdata.
  always_comb begin
    owner_next = OWN_NONE;
    if (if_gnt) begin
      owner_next = OWN_IF;
    end else if (d_gnt && !d_rw) begin
      owner_next = OWN_D;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: grants, memory port steering and read-response routing.
  // ---------------------------------------------------------------------------
  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (!reset) begin
      if (state == S_LOCKED) begin
        d_gnt = d_req;
      end else if (d_req && !(if_req && (burst_cnt == BURST_MAX))) begin
        d_gnt = 1'b1;
      end else if (if_req) begin
        if_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_rw    = 1'b0;
    if (if_gnt) begin
      mem_addr = if_addr;
    end else if (d_gnt) begin
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      mem_rw    = d_rw;
    end
  end

  // Gating with reset keeps a response in flight from leaking out while the
  // owner register is being cleared.
  always_comb begin
    if_rvalid = !reset && (rsp_owner == OWN_IF);
    d_rvalid  = !reset && (rsp_owner == OWN_D);
    if_rdata  = if_rvalid ? mem_rdata : '0;
    d_rdata   = d_rvalid  ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_umem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_umem_arbiter
//
// Directed bench for umem_arbiter with MAX_DATA_BURST = 4. A small word memory
// behind the umem port returns data one cycle after the read. On reset every
// word is loaded with 0xA500_0000 | byte_address, except 0x10 = 0xDEADBEEF,
// so expected read data follows directly from the address.
// Inputs change 1 time unit after the rising edge; outputs are checked 1 unit
// after that, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_umem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_rw;
  logic        d_lock;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rw;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:255];

  always #5 clk = ~clk;

  umem_arbiter #(.MAX_DATA_BURST(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_rw      (d_rw),
    .d_lock    (d_lock),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rw    (mem_rw),
    .mem_rdata (mem_rdata)
  );

  // umem stand-in: write on the grant edge, read data one cycle later.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hA500_0000 | 32'(i * 4);
      mem[4]    <= 32'hDEAD_BEEF;
      mem_rdata <= '0;
    end else begin
      if (mem_rw) mem[mem_addr[9:2]] <= mem_wdata;
      mem_rdata <= mem[mem_addr[9:2]];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after an input change.
  task automatic settle();
    #1;
  endtask

  initial begin
    reset   = 1'b1;
    if_req  = 1'b1;
    if_addr = 32'h10;
    d_req   = 1'b1;
    d_rw    = 1'b1;
    d_lock  = 1'b1;
    d_addr  = 32'h44;
    d_wdata = 32'h5555_AAAA;

    // ---- Reset: everything quiet even with both sides requesting ----------
    cyc();
    cyc();
    settle();
    check("rst_if_gnt",    32'(if_gnt),    32'd0);
    check("rst_d_gnt",     32'(d_gnt),     32'd0);
    check("rst_mem_rw",    32'(mem_rw),    32'd0);
    check("rst_mem_addr",  mem_addr,       32'd0);
    check("rst_mem_wdata", mem_wdata,      32'd0);
    check("rst_if_rvalid", 32'(if_rvalid), 32'd0);
    check("rst_d_rvalid",  32'(d_rvalid),  32'd0);

    reset  = 1'b0;
    if_req = 1'b0;
    d_req  = 1'b0;
    d_rw   = 1'b0;
    d_lock = 1'b0;

    // ---- Fetch only --------------------------------------------------------
    if_req  = 1'b1;
    if_addr = 32'h10;
    settle();
    check("f_if_gnt",   32'(if_gnt), 32'd1);
    check("f_d_gnt",    32'(d_gnt),  32'd0);
    check("f_mem_addr", mem_addr,    32'h10);
    check("f_mem_rw",   32'(mem_rw), 32'd0);
    cyc();
    if_req = 1'b0;
    settle();
    check("f_if_rvalid", 32'(if_rvalid), 32'd1);
    check("f_if_rdata",  if_rdata,       32'hDEAD_BEEF);
    check("f_d_rvalid",  32'(d_rvalid),  32'd0);
    check("f_d_rdata",   d_rdata,        32'd0);
    cyc();

    // ---- Contention: expect D,D,D,D,IF,D -----------------------------------
    if_req  = 1'b1;
    if_addr = 32'h0;
    d_req   = 1'b1;
    d_rw    = 1'b0;
    d_addr  = 32'h40;
    for (int i = 0; i < 6; i++) begin
      settle();
      check($sformatf("c%0d_if_gnt", i), 32'(if_gnt), (i == 4) ? 32'd1 : 32'd0);
      check($sformatf("c%0d_d_gnt", i),  32'(d_gnt),  (i == 4) ? 32'd0 : 32'd1);
      cyc();
      check($sformatf("c%0d_if_rvalid", i), 32'(if_rvalid),
            (i == 4) ? 32'd1 : 32'd0);
      check($sformatf("c%0d_if_rdata", i), if_rdata,
            (i == 4) ? 32'hA500_0000 : 32'd0);
      check($sformatf("c%0d_d_rvalid", i), 32'(d_rvalid),
            (i == 4) ? 32'd0 : 32'd1);
      check($sformatf("c%0d_d_rdata", i), d_rdata,
            (i == 4) ? 32'd0 : 32'hA500_0040);
    end
    if_req = 1'b0;
    d_req  = 1'b0;
    cyc();

    // ---- Write then read back ----------------------------------------------
    d_req   = 1'b1;
    d_rw    = 1'b1;
    d_addr  = 32'h80;
    d_wdata = 32'h1234_5678;
    settle();
    check("w_d_gnt",     32'(d_gnt),  32'd1);
    check("w_mem_rw",    32'(mem_rw), 32'd1);
    check("w_mem_addr",  mem_addr,    32'h80);
    check("w_mem_wdata", mem_wdata,   32'h1234_5678);
    cyc();
    d_req = 1'b0;
    d_rw  = 1'b0;
    settle();
    check("w_no_rvalid", 32'(d_rvalid), 32'd0);
    d_req = 1'b1;
    settle();
    check("rb_mem_rw", 32'(mem_rw), 32'd0);
    cyc();
    d_req = 1'b0;
    settle();
    check("rb_d_rvalid", 32'(d_rvalid), 32'd1);
    check("rb_d_rdata",  d_rdata,       32'h1234_5678);
    cyc();

    // ---- Lock: read 0x20, write 0x20, three reads, idle, unlock ------------
    if_req  = 1'b1;
    if_addr = 32'h4;
    d_req   = 1'b1;
    d_rw    = 1'b0;
    d_lock  = 1'b1;
    d_addr  = 32'h20;
    settle();
    check("l0_d_gnt",  32'(d_gnt),  32'd1);
    check("l0_if_gnt", 32'(if_gnt), 32'd0);
    cyc();
    d_rw    = 1'b1;
    d_wdata = 32'hCAFE_F00D;
    settle();
    check("l1_d_gnt",    32'(d_gnt),    32'd1);
    check("l1_if_gnt",   32'(if_gnt),   32'd0);
    check("l1_d_rvalid", 32'(d_rvalid), 32'd1);
    check("l1_d_rdata",  d_rdata,       32'hA500_0020);
    cyc();
    d_rw = 1'b0;
    settle();
    check("l2_d_rvalid", 32'(d_rvalid), 32'd0);
    // Reads in cycles 2..4 push the burst counter to saturation.
    for (int k = 2; k < 5; k++) begin
      check($sformatf("l%0d_if_gnt", k), 32'(if_gnt), 32'd0);
      check($sformatf("l%0d_d_gnt", k),  32'(d_gnt),  32'd1);
      cyc();
      check($sformatf("l%0d_d_rdata", k), d_rdata, 32'hCAFE_F00D);
    end
    d_req = 1'b0;
    settle();
    check("l5_if_gnt", 32'(if_gnt), 32'd0);
    cyc();
    // Lock drops with a data read in the same cycle: still LOCKED here.
    d_req  = 1'b1;
    d_lock = 1'b0;
    settle();
    check("l6_if_gnt", 32'(if_gnt), 32'd0);
    check("l6_d_gnt",  32'(d_gnt),  32'd1);
    cyc();
    d_req = 1'b0;
    settle();
    check("l7_if_gnt",   32'(if_gnt),   32'd1);
    check("l7_mem_addr", mem_addr,      32'h4);
    check("l7_d_rvalid", 32'(d_rvalid), 32'd1);
    check("l7_d_rdata",  d_rdata,       32'hCAFE_F00D);
    cyc();
    if_req = 1'b0;
    settle();
    check("l8_if_rvalid", 32'(if_rvalid), 32'd1);
    check("l8_if_rdata",  if_rdata,       32'hA500_0004);
    cyc();

    // ---- Back-to-back fetch reads ------------------------------------------
    if_req = 1'b1;
    for (int j = 0; j < 3; j++) begin
      if_addr = 32'(j * 4);
      settle();
      check($sformatf("b%0d_if_gnt", j), 32'(if_gnt), 32'd1);
      cyc();
      check($sformatf("b%0d_if_rvalid", j), 32'(if_rvalid), 32'd1);
      check($sformatf("b%0d_if_rdata", j), if_rdata,
            32'hA500_0000 | 32'(j * 4));
    end
    if_req = 1'b0;
    cyc();

    // ---- Reset during an outstanding read ----------------------------------
    if_req  = 1'b1;
    if_addr = 32'h10;
    settle();
    check("r_if_gnt", 32'(if_gnt), 32'd1);
    cyc();
    reset = 1'b1;
    settle();
    check("r_if_rvalid", 32'(if_rvalid), 32'd0);
    check("r_if_rdata",  if_rdata,       32'd0);
    check("r_if_gnt_rs", 32'(if_gnt),    32'd0);
    check("r_mem_addr",  mem_addr,       32'd0);
    cyc();
    reset  = 1'b0;
    if_req = 1'b0;
    settle();
    check("r_post_if_rvalid", 32'(if_rvalid), 32'd0);
    check("r_post_d_rvalid",  32'(d_rvalid),  32'd0);
    if_req = 1'b1;
    settle();
    check("r_post_if_gnt", 32'(if_gnt), 32'd1);
    cyc();
    if_req = 1'b0;
    settle();
    check("r_post_if_rvalid2", 32'(if_rvalid), 32'd1);
    check("r_post_if_rdata",   if_rdata,       32'hDEAD_BEEF);
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
